// File: rtl/sync_sample_tagger.sv
// Tags decimated samples with {sync_error, sync_counter} once host-aligned, into a FWFT FIFO.
// Push-to-out_valid latency 1 cycle; a push into a full FIFO without a same-cycle pop is dropped and counted.
module sync_sample_tagger #(
  parameter int DATA_WIDTH   = 24,
  parameter int COUNTER_SIZE = 19,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_ADDR    = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 sample_valid,
  input  logic [DATA_WIDTH-1:0]                sample_data,
  input  logic [COUNTER_SIZE-1:0]              sync_counter,
  input  logic                                 sync_error,
  input  logic                                 clear_overflow,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [COUNTER_SIZE+DATA_WIDTH:0]     out_data,
  output logic [FIFO_ADDR:0]                   fifo_level,
  output logic                                 aligned,
  output logic                                 overflow,
  output logic [7:0]                           drop_count
);

  localparam int W = 1 + COUNTER_SIZE + DATA_WIDTH;
  localparam logic [FIFO_ADDR:0] FULL_LVL = (FIFO_ADDR+1)'(FIFO_DEPTH);

  typedef enum logic {
    S_WAIT_ALIGN = 1'b0,
    S_RUN        = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           mem_q [FIFO_DEPTH];
  logic [W-1:0]           mem_d [FIFO_DEPTH];
  logic [FIFO_ADDR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR:0]     level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             drop_count_q, drop_count_d;

  logic tag_en;
  logic push_req;
  logic push;
  logic pop;
  logic drop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_ALIGN: if (enable && (sync_counter == '0)) state_d = S_RUN;
      S_RUN:        if (!enable) state_d = S_WAIT_ALIGN;
      default:      state_d = S_WAIT_ALIGN;
    endcase
  end

  always_comb begin
    // The alignment cycle itself already carries a valid (counter 0) timestamp.
    tag_en   = (state_q == S_RUN) || (enable && (sync_counter == '0));
    push_req = sample_valid && tag_en;
    pop      = out_ready && (level_q != '0);
    push     = push_req && ((level_q < FULL_LVL) || pop);
    drop     = push_req && !push;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push) begin
      mem_d[wr_ptr_q] = {sync_error, sync_counter, sample_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear_overflow) begin
      overflow_d   = drop;
      drop_count_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_WAIT_ALIGN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked entirely by level_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign aligned    = (state_q == S_RUN);
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_sync_sample_tagger.sv
// Directed stimulus for sync_sample_tagger; a negedge monitor checks popped words against a scoreboard queue.
module tb_sync_sample_tagger;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [23:0] sample_data;
  logic [18:0] sync_counter;
  logic        sync_error;
  logic        clear_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [43:0] out_data;
  logic [3:0]  fifo_level;
  logic        aligned;
  logic        overflow;
  logic [7:0]  drop_count;

  logic [43:0] exp_q[$];
  logic [43:0] w;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  sync_sample_tagger dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sync_counter(sync_counter), .sync_error(sync_error),
    .clear_overflow(clear_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level), .aligned(aligned),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Monitor: out_valid must track scoreboard occupancy; each handshake pops one word.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL sb_valid got %0b want %0b (queued %0d)", out_valid, exp_q.size() != 0, exp_q.size());
      end
      if (out_valid === 1'b1 && out_ready === 1'b1 && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        checks++;
        if (out_data !== w) begin
          errors++;
          $display("FAIL sb_word got %h want %h", out_data, w);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic sv, input logic [23:0] d, input logic [18:0] cnt,
                      input logic err, input logic rdy, input logic clr, input logic exp_push);
    sample_valid   = sv;
    sample_data    = d;
    sync_counter   = cnt;
    sync_error     = err;
    out_ready      = rdy;
    clear_overflow = clr;
    @(posedge clk);
    if (exp_push) exp_q.push_back({err, cnt, d});
    #1;
    sample_valid   = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 24'h0, 19'd1, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;
    sync_counter = 19'd1; sync_error = 1'b0; clear_overflow = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_aligned", aligned, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drops", drop_count, 0);
    mon_en = 1'b1;

    // Samples before counter 0 are discarded; the alignment-cycle sample is kept.
    enable = 1'b1;
    step(1'b1, 24'h000111, 19'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 24'h000222, 19'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 24'h000333, 19'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_not_aligned", aligned, 0);
    step(1'b1, 24'h000ABC, 19'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t1_valid", out_valid, 1);
    chk("t1_word", out_data, 64'h0000_0000_0ABC);
    chk("t1_aligned", aligned, 1);
    idle(1, 1'b1);

    // Streaming with out_ready=1: each word leaves one cycle after its strobe.
    step(1'b1, 24'hA00005, 19'd5, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t2_lvl_a", fifo_level, 1);
    idle(3, 1'b1);
    chk("t2_lvl_b", fifo_level, 0);
    step(1'b1, 24'hA00009, 19'd9, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t2_lvl_c", fifo_level, 1);
    idle(3, 1'b1);
    step(1'b1, 24'hA0000D, 19'd13, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t2_lvl_d", fifo_level, 1);
    idle(1, 1'b1);
    chk("t2_lvl_e", fifo_level, 0);

    // Fill past full with the consumer stalled.
    for (int i = 0; i < 10; i++)
      step(1'b1, 24'(32'h100 + i), 19'(20 + i), 1'b0, 1'b0, 1'b0, i < 8);
    chk("t3_level", fifo_level, 8);
    chk("t3_overflow", overflow, 1);
    chk("t3_drops", drop_count, 2);
    chk("t3_valid", out_valid, 1);

    // Push plus pop at full is accepted; clear coincident with a drop restarts at one.
    step(1'b1, 24'h000200, 19'd30, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t4_level", fifo_level, 8);
    chk("t4_overflow", overflow, 1);
    chk("t4_drops", drop_count, 2);
    step(1'b1, 24'h000201, 19'd31, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_clr_overflow", overflow, 1);
    chk("t4_clr_drops", drop_count, 1);
    step(1'b0, 24'h0, 19'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_cleared_ovf", overflow, 0);
    chk("t4_cleared_drops", drop_count, 0);
    idle(10, 1'b1);
    chk("t4_drained", fifo_level, 0);

    // sync_error is tagged per word; dropping enable leaves S_RUN after one cycle.
    step(1'b1, 24'h000555, 19'd40, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 24'h000556, 19'd41, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 24'h000557, 19'd42, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t5_aligned", aligned, 1);
    enable = 1'b0;
    step(1'b1, 24'h000558, 19'd43, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t5_unaligned", aligned, 0);
    step(1'b1, 24'h000559, 19'd44, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    chk("t5_drained", fifo_level, 0);

    // Reset with words queued discards them and the reset-cycle sample.
    enable = 1'b1;
    step(1'b0, 24'h0, 19'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_aligned", aligned, 1);
    for (int i = 0; i < 4; i++)
      step(1'b1, 24'(32'h300 + i), 19'(50 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_level_pre", fifo_level, 4);
    reset = 1'b1; sample_valid = 1'b1; sample_data = 24'h0003FF; sync_counter = 19'd60;
    @(posedge clk);
    exp_q.delete();
    #1 reset = 1'b0; sample_valid = 1'b0;
    chk("t6_level", fifo_level, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_state", aligned, 0);
    step(1'b1, 24'h0003AA, 19'd61, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_level_post", fifo_level, 0);
    chk("t6_state_post", aligned, 0);
    idle(2, 1'b1);

    chk("sb_empty", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
